// File: rtl/reg_scoreboard.sv
// Register scoreboard: per-register pending-write counters, issue/stall and busy summary; combinational outputs, state updates on the next edge.
// issue_ready drops when the destination counter is saturated. Optional macro SCOREBOARD_WB_BYPASS_EN clears a stall when its last pending write-back lands this cycle.
module reg_scoreboard #(
    parameter int CNT_W = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        issue_valid,
    input  logic [4:0]  issue_reg,
    output logic        issue_ready,
    input  logic        wb_valid,
    input  logic [4:0]  wb_reg,
    input  logic [4:0]  readreg1,
    input  logic [4:0]  readreg2,
    output logic        stall1,
    output logic        stall2,
    output logic        stall,
    output logic [31:0] busy_vec,
    output logic        any_busy,
    output logic [4:0]  first_busy,
    output logic        underflow_err
);
    localparam logic [CNT_W-1:0] MAXCNT = '1;
    localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);

    logic [CNT_W-1:0] count_q [32];
    logic [CNT_W-1:0] count_d [32];
    logic             underflow_q, underflow_d;
    logic             issue_acc, wb_act;

    assign issue_ready = (issue_reg == 5'd0) || (count_q[issue_reg] != MAXCNT);
    assign issue_acc   = issue_valid && issue_ready && (issue_reg != 5'd0);
    assign wb_act      = wb_valid && (wb_reg != 5'd0);

    always_comb begin
        for (int i = 0; i < 32; i++) count_d[i] = count_q[i];
        underflow_d = underflow_q;
        // Issue and write-back to the same register cancel out, even at count 0.
        if (!(issue_acc && wb_act && (issue_reg == wb_reg))) begin
            if (issue_acc) count_d[issue_reg] = count_q[issue_reg] + ONE;
            if (wb_act) begin
                if (count_q[wb_reg] != '0) count_d[wb_reg] = count_q[wb_reg] - ONE;
                else                       underflow_d     = 1'b1;
            end
        end
        count_d[0] = '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) count_q[i] <= '0;
            underflow_q <= 1'b0;
        end else begin
            for (int i = 0; i < 32; i++) count_q[i] <= count_d[i];
            underflow_q <= underflow_d;
        end
    end

    always_comb begin
        busy_vec   = '0;
        first_busy = 5'd0;
        for (int i = 0; i < 32; i++) busy_vec[i] = (count_q[i] != '0);
        // Scan downward so the lowest busy index is the last assignment.
        for (int i = 31; i >= 0; i--) begin
            if (busy_vec[i]) first_busy = 5'(i);
        end
    end

    assign any_busy      = |busy_vec;
    assign underflow_err = underflow_q;

`ifdef SCOREBOARD_WB_BYPASS_EN
    assign stall1 = busy_vec[readreg1] &&
                    !(wb_valid && (wb_reg == readreg1) && (count_q[readreg1] == ONE));
    assign stall2 = busy_vec[readreg2] &&
                    !(wb_valid && (wb_reg == readreg2) && (count_q[readreg2] == ONE));
`else
    assign stall1 = busy_vec[readreg1];
    assign stall2 = busy_vec[readreg2];
`endif
    assign stall = stall1 || stall2;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed bench for reg_scoreboard with hand-computed expectations (CNT_W = 2).
module tb_reg_scoreboard;
    logic        clk = 1'b0;
    logic        reset, issue_valid, wb_valid;
    logic [4:0]  issue_reg, wb_reg, readreg1, readreg2;
    logic        issue_ready, stall1, stall2, stall, any_busy, underflow_err;
    logic [31:0] busy_vec;
    logic [4:0]  first_busy;
    int          vecs = 0;
    int          errs = 0;
    logic        exp_byp_stall;

    reg_scoreboard #(.CNT_W(2)) dut (
        .clk(clk), .reset(reset),
        .issue_valid(issue_valid), .issue_reg(issue_reg), .issue_ready(issue_ready),
        .wb_valid(wb_valid), .wb_reg(wb_reg),
        .readreg1(readreg1), .readreg2(readreg2),
        .stall1(stall1), .stall2(stall2), .stall(stall),
        .busy_vec(busy_vec), .any_busy(any_busy), .first_busy(first_busy),
        .underflow_err(underflow_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the edge; combinational checks follow 1 unit later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        issue_valid = 1'b0; issue_reg = 5'd0;
        wb_valid    = 1'b0; wb_reg    = 5'd0;
        #1;
    endtask

    task automatic issue_only(input logic [4:0] r);
        issue_valid = 1'b1; issue_reg = r; wb_valid = 1'b0;
        step(); idle();
    endtask

    task automatic wb_only(input logic [4:0] r);
        wb_valid = 1'b1; wb_reg = r; issue_valid = 1'b0;
        step(); idle();
    endtask

    initial begin
        reset = 1'b1; readreg1 = 5'd0; readreg2 = 5'd0;
        idle();
        step(); step();
        reset = 1'b0; #1;
        issue_reg = 5'd5; readreg1 = 5'd5; readreg2 = 5'd9; #1;
        chk("rst_issue_ready", issue_ready, 1);
        chk("rst_stall", {stall1, stall2, stall}, 0);
        chk("rst_busy_vec", busy_vec, 0);
        chk("rst_any_busy", any_busy, 0);
        chk("rst_first_busy", first_busy, 0);
        chk("rst_underflow", underflow_err, 0);

        // Single issue to r5
        idle(); issue_only(5'd5);
        readreg1 = 5'd5; readreg2 = 5'd0; #1;
        chk("r5_busy_vec", busy_vec, 32'h0000_0020);
        chk("r5_first_busy", first_busy, 5);
        chk("r5_stall1", stall1, 1);
        chk("r5_stall", stall, 1);
        chk("r5_any_busy", any_busy, 1);
        wb_only(5'd5);
        chk("r5_cleared", busy_vec, 0);

        // Saturation on r7
        issue_only(5'd7); issue_only(5'd7); issue_only(5'd7);
        issue_reg = 5'd7; #1;
        chk("r7_full_ready", issue_ready, 0);
        issue_reg = 5'd8; #1;
        chk("r8_ready_while_r7_full", issue_ready, 1);
        issue_only(5'd7);
        wb_only(5'd7); wb_only(5'd7);
        chk("r7_one_left", busy_vec, 32'h0000_0080);
        wb_only(5'd7);
        chk("r7_drained", busy_vec[7], 0);
        chk("r7_no_underflow", underflow_err, 0);

        // Same-cycle issue+wb on r9, then underflow
        issue_only(5'd9);
        issue_valid = 1'b1; issue_reg = 5'd9; wb_valid = 1'b1; wb_reg = 5'd9;
        step(); idle();
        chk("r9_cancel_busy", busy_vec, 32'h0000_0200);
        chk("r9_cancel_uf", underflow_err, 0);
        wb_only(5'd9);
        chk("r9_first_wb_busy", busy_vec, 0);
        chk("r9_first_wb_uf", underflow_err, 0);
        wb_only(5'd9);
        chk("r9_underflow", underflow_err, 1);
        step(); step();
        chk("r9_underflow_sticky", underflow_err, 1);
        issue_valid = 1'b1; issue_reg = 5'd9; wb_valid = 1'b1; wb_reg = 5'd9;
        step(); idle();
        chk("r9_cancel_at_zero", busy_vec, 0);
        reset = 1'b1; step(); reset = 1'b0; #1;
        chk("uf_cleared_by_reset", underflow_err, 0);

        // Register 0 is never tracked
        issue_valid = 1'b1; issue_reg = 5'd0; wb_valid = 1'b1; wb_reg = 5'd0;
        readreg1 = 5'd0; #1;
        chk("r0_issue_ready", issue_ready, 1);
        step(); idle();
        chk("r0_busy_vec", busy_vec, 0);
        chk("r0_stall1", stall1, 0);
        chk("r0_underflow", underflow_err, 0);

        // Priority encoder and write-back bypass
        issue_only(5'd3); issue_only(5'd12); issue_only(5'd12);
        chk("pe_busy_vec", busy_vec, 32'h0000_1008);
        chk("pe_first_3", first_busy, 3);
        readreg2 = 5'd3; #1;
        chk("pe_stall2_pending", stall2, 1);
`ifdef SCOREBOARD_WB_BYPASS_EN
        exp_byp_stall = 1'b0;
`else
        exp_byp_stall = 1'b1;
`endif
        wb_valid = 1'b1; wb_reg = 5'd3; #1;
        chk("bypass_stall2", stall2, {31'd0, exp_byp_stall});
        readreg1 = 5'd12; #1;
        chk("bypass_not_last_stall1", stall1, 1);
        step(); idle();
        chk("pe_first_12", first_busy, 12);
        chk("pe_stall2_after_wb", stall2, 0);

        // Issue and write-back to different registers in one cycle
        issue_valid = 1'b1; issue_reg = 5'd20; wb_valid = 1'b1; wb_reg = 5'd12;
        step(); idle();
        chk("diff_regs_busy", busy_vec, 32'h0010_1000);
        chk("diff_regs_stall1", stall1, 1);
        issue_only(5'd31); wb_only(5'd12); wb_only(5'd20);
        chk("r31_busy_vec", busy_vec, 32'h8000_0000);
        chk("r31_first_busy", first_busy, 31);

        // Reset overrides a same-cycle issue
        issue_only(5'd4);
        reset = 1'b1; issue_valid = 1'b1; issue_reg = 5'd4;
        step(); reset = 1'b0; idle();
        readreg1 = 5'd4; readreg2 = 5'd31; issue_reg = 5'd4; #1;
        chk("rst2_busy_vec", busy_vec, 0);
        chk("rst2_any_busy", any_busy, 0);
        chk("rst2_first_busy", first_busy, 0);
        chk("rst2_stall", {stall1, stall2, stall}, 0);
        chk("rst2_issue_ready", issue_ready, 1);
        chk("rst2_underflow", underflow_err, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
